// File: rtl/gol_pkg.sv
// Shared definitions for the Game-of-Life board blocks: board geometry,
// loader opcodes and the loader state encoding.
package gol_pkg;

   localparam int LOG_W_DEF = 6;
   localparam int LOG_H_DEF = 5;

   localparam logic [3:0] OP_NOP    = 4'h0;
   localparam logic [3:0] OP_CLEAR  = 4'h1;
   localparam logic [3:0] OP_SET_XY = 4'h2;
   localparam logic [3:0] OP_ROW8   = 4'h3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GET_X,
      ST_GET_Y,
      ST_GET_ROW,
      ST_CLEAR,
      ST_WRITE8
   } loader_state_t;

endpackage

// File: rtl/board_loader.sv
// Byte-command loader that clears the board or writes 8-cell row patterns
// at a cursor, driving a registered single-cell write port.
module board_loader
   import gol_pkg::*;
#(
   parameter int LOG_W = LOG_W_DEF,
   parameter int LOG_H = LOG_H_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [7:0]             in_data,
   output logic                   in_ready,
   output logic                   wr_en,
   output logic [LOG_W+LOG_H-1:0] wr_addr,
   output logic                   wr_data,
   output logic                   busy,
   output logic                   err
);

   localparam int AW = LOG_W + LOG_H;
   localparam logic [AW-1:0] A_ONE = AW'(1);

   loader_state_t   state, state_n;
   logic [AW-1:0]   cursor, cursor_n;
   logic [AW-1:0]   clr_cnt, clr_cnt_n;
   logic [LOG_W-1:0] x_tmp, x_tmp_n;
   logic [7:0]      row_byte, row_byte_n;
   logic [2:0]      wr_cnt, wr_cnt_n, wr_nxt;
   logic            wr_en_n, wr_data_n, err_n;
   logic [AW-1:0]   wr_addr_n;
   logic            accept;

   assign in_ready = (state == ST_IDLE) || (state == ST_GET_X) ||
                     (state == ST_GET_Y) || (state == ST_GET_ROW);
   assign busy     = (state != ST_IDLE);
   assign accept   = in_valid && in_ready;
   assign wr_nxt   = wr_cnt + 3'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         cursor   <= '0;
         clr_cnt  <= '0;
         x_tmp    <= '0;
         row_byte <= '0;
         wr_cnt   <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_n;
         cursor   <= cursor_n;
         clr_cnt  <= clr_cnt_n;
         x_tmp    <= x_tmp_n;
         row_byte <= row_byte_n;
         wr_cnt   <= wr_cnt_n;
         wr_en    <= wr_en_n;
         wr_addr  <= wr_addr_n;
         wr_data  <= wr_data_n;
         err      <= err_n;
      end
   end

   // Write-port values are computed one cycle ahead so the port itself is a
   // plain register; the row-major cursor advances as a single {y,x} counter.
   always_comb begin
      state_n    = state;
      cursor_n   = cursor;
      clr_cnt_n  = clr_cnt;
      x_tmp_n    = x_tmp;
      row_byte_n = row_byte;
      wr_cnt_n   = wr_cnt;
      wr_en_n    = 1'b0;
      wr_addr_n  = wr_addr;
      wr_data_n  = wr_data;
      err_n      = err;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               case (in_data[7:4])
                  OP_NOP: ;
                  OP_CLEAR: begin
                     state_n   = ST_CLEAR;
                     wr_en_n   = 1'b1;
                     wr_addr_n = '0;
                     wr_data_n = 1'b0;
                     clr_cnt_n = A_ONE;
                  end
                  OP_SET_XY: state_n = ST_GET_X;
                  OP_ROW8:   state_n = ST_GET_ROW;
                  default:   err_n   = 1'b1;
               endcase
            end
         end
         ST_GET_X: begin
            if (accept) begin
               x_tmp_n = in_data[LOG_W-1:0];
               state_n = ST_GET_Y;
            end
         end
         ST_GET_Y: begin
            if (accept) begin
               cursor_n = {in_data[LOG_H-1:0], x_tmp};
               state_n  = ST_IDLE;
            end
         end
         ST_GET_ROW: begin
            if (accept) begin
               state_n    = ST_WRITE8;
               row_byte_n = in_data;
               wr_en_n    = 1'b1;
               wr_addr_n  = cursor;
               wr_data_n  = in_data[7];
               cursor_n   = cursor + A_ONE;
               wr_cnt_n   = 3'd0;
            end
         end
         ST_WRITE8: begin
            if (wr_cnt == 3'd7) begin
               state_n = ST_IDLE;
            end else begin
               wr_en_n   = 1'b1;
               wr_addr_n = cursor;
               wr_data_n = row_byte[~wr_nxt];
               cursor_n  = cursor + A_ONE;
               wr_cnt_n  = wr_nxt;
            end
         end
         ST_CLEAR: begin
            // clr_cnt wraps to zero once the last address has been issued.
            if (clr_cnt == '0) begin
               state_n = ST_IDLE;
            end else begin
               wr_en_n   = 1'b1;
               wr_addr_n = clr_cnt;
               wr_data_n = 1'b0;
               clr_cnt_n = clr_cnt + A_ONE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_board_loader.sv
// Scoreboard bench for board_loader: expected writes are queued as commands
// are sent and matched against the write port as it fires.
module tb_board_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        wr_en;
   logic [10:0] wr_addr;
   logic        wr_data;
   logic        busy;
   logic        err;

   int n_cmp  = 0;
   int n_fail = 0;
   int model_x = 0;
   int model_y = 0;
   logic [11:0] exp_q[$];

   board_loader dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Every write seen on the port must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!reset && wr_en) begin
         if (exp_q.size() == 0) begin
            check_output("spurious_wr_en", wr_en, 0);
         end else begin
            logic [11:0] e;
            e = exp_q.pop_front();
            check_output("wr_addr", wr_addr, e[11:1]);
            check_output("wr_data", wr_data, e[0]);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (!in_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check_output("send_timeout", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 5000) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic push_row(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         logic [10:0] a;
         a = 11'(model_y * 64 + model_x);
         exp_q.push_back({a, b[i]});
         model_x++;
         if (model_x == 64) begin
            model_x = 0;
            model_y = (model_y + 1) % 32;
         end
      end
   endtask

   task automatic apply_stimulus_set_xy(input int x, input int y);
      send_byte(8'h20);
      check_output("get_x_busy", busy, 1);
      check_output("get_x_ready", in_ready, 1);
      send_byte(8'(x));
      send_byte(8'(y));
      model_x = x;
      model_y = y;
   endtask

   task automatic apply_stimulus_row8(input logic [7:0] b);
      int n;
      push_row(b);
      send_byte(8'h30);
      send_byte(b);
      check_output("row8_first_wr", wr_en, 1);
      wait_idle(n);
      check_output("row8_cycles", n, 8);
      check_output("row8_queue_empty", exp_q.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;
      reset = 1'b1;
      in_valid = 1'b0;
      in_data = 8'h00;
      repeat (3) @(negedge clk);
      check_output("rst_wr_en", wr_en, 0);
      check_output("rst_wr_addr", wr_addr, 0);
      check_output("rst_wr_data", wr_data, 0);
      check_output("rst_err", err, 0);
      check_output("rst_busy", busy, 0);
      reset = 1'b0;
      check_output("rel_ready", in_ready, 1);

      // Full-board clear
      for (int a = 0; a < 2048; a++) exp_q.push_back({11'(a), 1'b0});
      send_byte(8'h10);
      check_output("clr_first_wr", wr_en, 1);
      check_output("clr_ready_low", in_ready, 0);
      wait_idle(n);
      check_output("clr_cycles", n, 2048);
      check_output("clr_queue_empty", exp_q.size(), 0);

      // Cursor set then row pattern, and a second row to confirm the cursor
      apply_stimulus_set_xy(5, 3);
      apply_stimulus_row8(8'hA5);
      apply_stimulus_row8(8'h81);

      // Row crossing the bottom-right corner wraps to row 0
      apply_stimulus_set_xy(60, 31);
      apply_stimulus_row8(8'hFF);

      // Illegal opcode is sticky and NOP does not clear it
      send_byte(8'h70);
      check_output("err_set", err, 1);
      check_output("err_ready", in_ready, 1);
      check_output("err_busy", busy, 0);
      send_byte(8'h00);
      check_output("err_after_nop", err, 1);

      // Reset in the middle of a clear
      for (int a = 0; a < 100; a++) exp_q.push_back({11'(a), 1'b0});
      send_byte(8'h10);
      repeat (99) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check_output("abort_wr_en", wr_en, 0);
      check_output("abort_busy", busy, 0);
      check_output("abort_queue_empty", exp_q.size(), 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_output("abort_ready", in_ready, 1);
      check_output("abort_err", err, 0);
      check_output("abort_wr_addr", wr_addr, 0);
      repeat (20) @(negedge clk);
      check_output("abort_still_idle", busy, 0);

      // Bytes offered during WRITE8 must be ignored
      apply_stimulus_set_xy(0, 0);
      push_row(8'h3C);
      send_byte(8'h30);
      in_valid = 1'b1;
      in_data = 8'h3C;
      @(posedge clk);
      @(negedge clk);
      n = 0;
      while (busy && n < 20) begin
         in_data = n[0] ? 8'h10 : 8'h70;
         check_output("w8_ready_low", in_ready, 0);
         @(negedge clk);
         n++;
      end
      check_output("w8_cycles", n, 8);
      in_data = 8'h20;
      check_output("w8_ready_idle", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check_output("w8_setxy_taken", busy, 1);
      send_byte(8'h07);
      send_byte(8'h02);
      model_x = 7;
      model_y = 2;
      check_output("w8_no_err", err, 0);
      check_output("w8_queue_empty", exp_q.size(), 0);
      apply_stimulus_row8(8'h80);

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
